gf2m_arith_unit: RTL and testbench
==================================

GF2M_ARITH_UNIT -- requirements
Module: gf2m_arith_unit

Interface
REQ-001 Parameter M, default 8: field degree; all operand and result widths are M bits.
REQ-002 Parameter POLY, default 8'h1D (M bits): primitive polynomial low coefficients; x^M term implied (default 0x11D).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request strobe.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 in_mode  input  2  operation: 00 MUL, 01 INV, 10 DIV, 11 SQR.
REQ-008 in_x  input  M  operand x (dividend for DIV; ignored for INV and SQR).
REQ-009 in_y  input  M  operand y (divisor for DIV; sole operand for INV and SQR).
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_z  output  M  result.
REQ-013 out_dz  output  1  zero-divisor flag, qualified by out_valid.

Function
REQ-014 The unit SHALL perform MUL z=x*y, SQR z=y*y, INV z=y^-1, DIV z=x*y^-1 in GF(2^M) mod POLY.
REQ-015 The FSM SHALL have states IDLE, EXP, DONE; in_ready SHALL equal (state==IDLE).
REQ-016 A request SHALL be accepted on a rising edge with in_valid && in_ready; operands and mode are captured at that edge only.
REQ-017 MUL/SQR on acceptance: acc<=product, state->DONE; out_valid SHALL rise 1 cycle after acceptance.
REQ-018 INV/DIV on acceptance: sq<=y*y, acc<=1 (INV) or x (DIV), cnt<=M-1, state->EXP.
REQ-019 Each EXP cycle: acc<=acc*sq, sq<=sq*sq, cnt<=cnt-1; on the cycle cnt==1 state->DONE.
REQ-020 INV/DIV latency SHALL be exactly M-1 cycles from acceptance to out_valid (7 for M=8); acc then holds x*y^(2^M-2).
REQ-021 out_z SHALL equal acc and out_valid SHALL equal (state==DONE).
REQ-022 In DONE with out_ready low, out_z, out_dz, out_valid SHALL hold unchanged.
REQ-023 In DONE with out_ready high, the state SHALL return to IDLE next edge; no new request is accepted in that same cycle.
REQ-024 INV/DIV with y==0 SHALL complete at normal latency with out_z=0 and out_dz=1; out_dz SHALL be 0 in every other case.
REQ-025 in_valid while busy SHALL be ignored; requesters hold in_valid until in_ready.
REQ-026 Iteration counter width SHALL be clog2(M); M SHALL be in 2..16.

Reset
REQ-027 While rst is high: state=IDLE, acc=0, sq=0, cnt=0, out_dz=0, hence out_valid=0, out_z=0, in_ready=1.
REQ-028 rst asserted mid-EXP or in DONE SHALL abort the operation; the result is discarded and no out_valid pulse follows.
REQ-029 First acceptance is possible on the first rising edge after rst deasserts.

Structure
REQ-030 A shared package gf2m_pkg SHALL hold the mode encodings (MUL, INV, DIV, SQR) and the default M and POLY constants.
REQ-031 One sub-module gf2m_mul (parameters M, POLY; combinational x*y mod POLY) SHALL be used, instantiated twice (acc*sq path, squaring path); the load-path products reuse these instances via input muxing.
REQ-032 No lookup tables; the datapath SHALL scale with M through parameters only.

Verification (M=8, POLY=8'h1D)
REQ-033 MUL x=0x80,y=0x02 -> out_z=0x1D, out_dz=0, out_valid 1 cycle after acceptance.
REQ-034 INV y=0x02 -> out_z=0x8E after exactly 7 cycles; INV y=0x03 -> 0xF4; SQR y=0x80 -> 0x13 after 1 cycle.
REQ-035 DIV x=0x04,y=0x02 -> 0x02; DIV x=0x01,y=0x00 -> out_z=0x00, out_dz=1, 7-cycle latency.
REQ-036 out_ready held low 5 cycles in DONE -> out_z/out_valid stable, in_ready=0; in_valid pulses during EXP are ignored.
REQ-037 rst pulsed at EXP cycle 3 of INV y=0x02 -> out_valid never rises; next INV y=0x04 -> 0x47.
REQ-038 Exhaustive: all 255 nonzero y, INV then MUL(y,result) -> 0x01 each time.

Source files
------------

// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared mode/state encodings and default field parameters
package gf2m_pkg;
  localparam int M_DEF = 8;
  localparam logic [7:0] POLY_DEF = 8'h1D;
  typedef enum logic [1:0] {
    MODE_MUL = 2'b00,
    MODE_INV = 2'b01,
    MODE_DIV = 2'b10,
    MODE_SQR = 2'b11
  } mode_e;
  typedef enum logic [1:0] {IDLE, EXP, DONE} state_e;
endpackage

// File: rtl/gf2m_mul.sv
// gf2m_mul: combinational GF(2^M) multiply, shift-and-add with reduction by POLY
module gf2m_mul
  import gf2m_pkg::*;
#(
  parameter int M = M_DEF,
  parameter logic [M-1:0] POLY = M'(POLY_DEF)
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);
  logic [M-1:0] t;
  // accumulate a*x^i for each set bit of b, reducing a*x^i as it is shifted up
  always_comb begin
    p = '0;
    t = a;
    for (int i = 0; i < M; i++) begin
      p = p ^ (b[i] ? t : '0);
      t = {t[M-2:0], 1'b0} ^ (t[M-1] ? POLY : '0);
    end
  end
endmodule

// File: rtl/gf2m_arith_unit.sv
// gf2m_arith_unit: GF(2^M) MUL/SQR in one cycle, INV/DIV by square-and-multiply over M-1 cycles
module gf2m_arith_unit
  import gf2m_pkg::*;
#(
  parameter int M = M_DEF,
  parameter logic [M-1:0] POLY = M'(POLY_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [M-1:0] in_x,
  input  logic [M-1:0] in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_z,
  output logic         out_dz
);
  localparam int CW = $clog2(M);
  state_e state, nxt;
  logic [M-1:0] acc, sq, ma, mb, sa, p0, p1;
  logic [CW-1:0] cnt;
  logic dz, idle, accept, direct;
  assign idle      = state == IDLE;
  assign in_ready  = idle;
  assign out_valid = state == DONE;
  assign out_z     = acc;
  assign out_dz    = dz;
  assign accept    = idle && in_valid;
  assign direct    = in_mode == MODE_MUL || in_mode == MODE_SQR;
  // in IDLE the multipliers see the request operands, otherwise the running acc/sq
  assign ma = idle ? in_x : acc;
  assign mb = idle ? in_y : sq;
  assign sa = idle ? in_y : sq;
  gf2m_mul #(.M(M), .POLY(POLY)) u_mul_acc (.a(ma), .b(mb), .p(p0));
  gf2m_mul #(.M(M), .POLY(POLY)) u_mul_sq  (.a(sa), .b(sa), .p(p1));
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state: direct ops finish at once, INV/DIV iterate until cnt reaches 1
  always_comb begin
    nxt = accept ? (direct ? DONE : EXP) :
          (state == EXP && cnt == CW'(1)) ? DONE :
          (state == DONE && out_ready) ? IDLE : state;
  end
  // datapath: load on acceptance, then acc*=sq, sq=sq^2 each EXP cycle giving x*y^(2^M-2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sq  <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else if (accept) begin
      acc <= in_mode == MODE_MUL ? p0 : in_mode == MODE_SQR ? p1 : in_mode == MODE_INV ? M'(1) : in_x;
      sq  <= p1;
      cnt <= CW'(M - 1);
      dz  <= !direct && in_y == '0;
    end else if (state == EXP) begin
      acc <= p0;
      sq  <= p1;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: tb/tb_gf2m_arith_unit.sv
// tb_gf2m_arith_unit: vector table, random ops vs log/antilog model, handshake/reset corner cases
module tb_gf2m_arith_unit;
  import gf2m_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [1:0] in_mode = 2'b00;
  logic [7:0] in_x = 8'h00, in_y = 8'h00;
  logic in_ready, out_valid, out_dz;
  logic [7:0] out_z;
  int checks = 0, errors = 0;
  int exp_t[255];
  int log_t[256];

  gf2m_arith_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_dz(out_dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] x, y, z;
    logic dz;
    int edges;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // reference field arithmetic via discrete log over generator 0x02, modulus 0x11D
  function automatic int gmul(input int a, input int b);
    return (a == 0 || b == 0) ? 0 : exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction
  function automatic int ginv(input int b);
    return b == 0 ? 0 : exp_t[(255 - log_t[b]) % 255];
  endfunction
  function automatic int ref_z(input int mode, input int x, input int y);
    case (mode)
      0: return gmul(x, y);
      1: return ginv(y);
      2: return gmul(x, ginv(y));
      default: return gmul(y, y);
    endcase
  endfunction

  // edges counts rising edges after the acceptance edge until out_valid is seen
  task automatic start_op(input int mode, input int x, input int y);
    int t = 0;
    while (!in_ready && t < 64) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 64) chk("ready_timeout", 0, 1);
    @(negedge clk);
    in_mode = 2'(mode); in_x = 8'(x); in_y = 8'(y); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int z, output int dz, output int edges);
    edges = 0;
    while (!out_valid && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    z = int'(out_z);
    dz = int'(out_dz);
  endtask

  task automatic run_op(input int mode, input int x, input int y, output int z, output int dz, output int edges);
    start_op(mode, x, y);
    wait_done(z, dz, edges);
    @(posedge clk); #1;
  endtask

  initial begin
    int z, dz, e, r, v, m, x, y, z0;
    bit seen;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v;
      log_t[v] = i;
      v = (v << 1) ^ ((v & 'h80) != 0 ? 'h11D : 0);
    end
    vt[0] = '{MODE_MUL, 8'h80, 8'h02, 8'h1D, 1'b0, 0};
    vt[1] = '{MODE_INV, 8'h00, 8'h02, 8'h8E, 1'b0, 7};
    vt[2] = '{MODE_INV, 8'h00, 8'h03, 8'hF4, 1'b0, 7};
    vt[3] = '{MODE_SQR, 8'h00, 8'h80, 8'h13, 1'b0, 0};
    vt[4] = '{MODE_DIV, 8'h04, 8'h02, 8'h02, 1'b0, 7};
    vt[5] = '{MODE_DIV, 8'h01, 8'h00, 8'h00, 1'b1, 7};
    vt[6] = '{MODE_MUL, 8'h00, 8'hFF, 8'h00, 1'b0, 0};
    vt[7] = '{MODE_INV, 8'h00, 8'h00, 8'h00, 1'b1, 7};
    vt[8] = '{MODE_INV, 8'h00, 8'h01, 8'h01, 1'b0, 7};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_dz", out_dz, 0);
    @(negedge clk) rst = 1'b0;
    foreach (vt[i]) begin
      run_op(vt[i].mode, vt[i].x, vt[i].y, z, dz, e);
      chk($sformatf("vec%0d_z", i), z, vt[i].z);
      chk($sformatf("vec%0d_dz", i), dz, vt[i].dz);
      chk($sformatf("vec%0d_lat", i), e, vt[i].edges);
    end
    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(0, 3);
      x = $urandom_range(0, 255);
      y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      run_op(m, x, y, z, dz, e);
      chk($sformatf("rnd%0d_m%0d_x%0h_y%0h_z", i, m, x, y), z, ref_z(m, x, y));
      chk($sformatf("rnd%0d_dz", i), dz, (m == 1 || m == 2) && y == 0);
      chk($sformatf("rnd%0d_lat", i), e, (m == 1 || m == 2) ? 7 : 0);
    end
    out_ready = 1'b0;
    start_op(MODE_MUL, 'h53, 'hCA);
    wait_done(z0, dz, e);
    chk("hold_first_z", z0, gmul('h53, 'hCA));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", i), out_valid, 1);
      chk($sformatf("hold%0d_z", i), out_z, z0);
      chk($sformatf("hold%0d_dz", i), out_dz, 0);
      chk($sformatf("hold%0d_in_ready", i), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_mode = MODE_SQR; in_x = 8'h00; in_y = 8'h80;
    @(posedge clk); #1;
    chk("done_exit_valid", out_valid, 0);
    chk("done_exit_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("after_exit_valid", out_valid, 1);
    chk("after_exit_z", out_z, gmul('h80, 'h80));
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    start_op(MODE_INV, 0, 'h03);
    @(negedge clk);
    in_valid = 1'b1; in_mode = MODE_MUL; in_x = 8'h01; in_y = 8'h01;
    @(posedge clk); #1;
    @(negedge clk) in_valid = 1'b0;
    wait_done(z, dz, e);
    chk("busy_ignore_z", z, ginv('h03));
    chk("busy_ignore_lat", e + 1, 7);
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("busy_ignore_no_extra", seen, 0);
    start_op(MODE_INV, 0, 'h02);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("abort_rst_valid", out_valid, 0);
    chk("abort_rst_in_ready", in_ready, 1);
    chk("abort_rst_z", out_z, 0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("abort_no_valid", seen, 0);
    run_op(MODE_INV, 0, 'h04, z, dz, e);
    chk("abort_next_z", z, 'h47);
    chk("abort_next_lat", e, 7);
    for (int i = 1; i < 256; i++) begin
      run_op(MODE_INV, 0, i, r, dz, e);
      chk($sformatf("exh_inv_%0h", i), r, ginv(i));
      run_op(MODE_MUL, i, r, z, dz, e);
      chk($sformatf("exh_prod_%0h", i), z, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
